// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and baud divisor helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// clr restarts the period so the first bit lines up with the frame accept edge.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic bit_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || (cnt_q == CNT_MAX)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_tick = (cnt_q == CNT_MAX) && !clr;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter, 8N1 LSB first, idle-high line; 8E1 when UART_TX_PARITY_EN is defined.
// sout is registered so it drops on the accept edge and returns high asynchronously on reset.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = 50000000,
   parameter int BAUD_RATE    = 9600,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] in_data,
   output logic       sout,
   output logic       busy,
   output logic       done
);

   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 sout_q, sout_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 baud_clr;
   logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk      (clk),
      .rst      (rst),
      .clr      (baud_clr),
      .bit_tick (bit_tick)
   );

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      sout_d    = sout_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      baud_clr  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            sout_d = 1'b1;
            busy_d = 1'b0;
            if (start) begin
               shift_d   = in_data;
               bit_idx_d = '0;
               sout_d    = 1'b0;
               busy_d    = 1'b1;
               baud_clr  = 1'b1;
               state_d   = START;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^in_data;
`endif
            end
         end
         START: begin
            if (bit_tick) begin
               sout_d    = shift_q[0];
               bit_idx_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            // sout is one register stage ahead, so it loads the bit about to reach shift[0].
            if (bit_tick) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  sout_d  = parity_q;
                  state_d = PARITY;
`else
                  sout_d  = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  sout_d    = shift_q[1];
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (bit_tick) begin
               sout_d  = 1'b1;
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               sout_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            sout_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         bit_idx_q <= '0;
         shift_q   <= '0;
         sout_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         sout_q    <= sout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   assign sout = sout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomised bench for uart_transmitter: a line-level frame model predicts sout per cycle,
// and a mid-bit sampler recovers each byte as a receiver would.
module tb_uart_transmitter;

   localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS   = 11;
   localparam bit PAR_ON  = 1'b1;
`else
   localparam int NBITS   = 10;
   localparam bit PAR_ON  = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] in_data;
   logic       sout;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   uart_transmitter #(
      .CLK_FREQ  (80),
      .BAUD_RATE (10)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .in_data (in_data),
      .sout    (sout),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Line level of bit slot k of a frame carrying d: start, 8 data LSB first, [even parity], stop.
   function automatic logic exp_bit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (PAR_ON && k == 9) return ^d;
      return 1'b1;
   endfunction

   // Caller has set start=1/in_data=d at a negedge; the next posedge accepts the frame.
   task automatic xmit(input logic [7:0] d, input bit b2b, input logic [7:0] nd);
      logic [7:0] rx;
      int k;
      rx = '0;
      @(posedge clk);
      for (int c = 0; c < NBITS * CPB; c++) begin
         @(negedge clk);
         k = c / CPB;
         chk("sout", sout, exp_bit(d, k));
         chk("busy", busy, 1);
         chk("done_early", done, 0);
         if ((c % CPB) == CPB / 2 && k >= 1 && k <= 8) rx[k-1] = sout;
         start   = ($urandom_range(3) == 0);
         in_data = $urandom_range(1) ? 8'h3C : 8'($urandom);
      end
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("busy_end", busy, 0);
      chk("sout_end", sout, 1);
      chk("rx_byte", rx, d);
      if (b2b) begin
         start   = 1'b1;
         in_data = nd;
      end else begin
         start   = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_sout", sout, 1);
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
      end
   endtask

   task automatic send(input logic [7:0] d);
      start   = 1'b1;
      in_data = d;
      xmit(d, 1'b0, 8'h00);
      idle($urandom_range(4, 1));
   endtask

   initial begin
      logic [7:0] a, b;
      rst     = 1'b0;
      start   = 1'b0;
      in_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_sout", sout, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b1;
      idle(3);

      send(8'hA5);
      send(8'h07);

      // Back-to-back: second start held through the done cycle.
      start   = 1'b1;
      in_data = 8'h00;
      xmit(8'h00, 1'b1, 8'hFF);
      xmit(8'hFF, 1'b0, 8'h00);
      idle(2);

      for (int f = 0; f < 6; f++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         if (f[0]) begin
            start   = 1'b1;
            in_data = a;
            xmit(a, 1'b1, b);
            xmit(b, 1'b0, 8'h00);
            idle($urandom_range(3, 1));
         end else begin
            send(a);
         end
      end

      // Abort during data bit 3: sout and busy must recover without a clock edge.
      start   = 1'b1;
      in_data = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4 * CPB + 1) @(negedge clk);
      chk("pre_abort_busy", busy, 1);
      rst = 1'b0;
      #1;
      chk("abort_sout", sout, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (2) @(negedge clk);
      chk("abort_hold_done", done, 0);
      rst = 1'b1;
      idle(2);
      send(8'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
